// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge: FSM states, AHB
// transfer/response encodings and default bus geometry.
package bridge_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_SLAVES = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RENABLE,
        WWAIT,
        WRITE,
        WENABLE,
        ERR1,
        ERR2
    } state_t;

endpackage

// File: rtl/bridge_addr_decode.sv
// Address decoder: maps an AHB address onto the APB window and produces a
// hit flag plus a one-hot slave select. Purely combinational.
module bridge_addr_decode
    import bridge_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               SLAVES    = DEFAULT_SLAVES,
    parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(32'h8000_0000),
    parameter int               SLOT_BITS = 26
) (
    input  logic [WIDTH-1:0]  addr,
    output logic              hit,
    output logic [SLAVES-1:0] sel
);

    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] slot;

    // Offset into the window; below-base addresses wrap and are rejected by
    // the explicit lower-bound compare.
    assign offset = addr - BASE_ADDR;
    assign slot   = offset >> SLOT_BITS;
    assign hit    = (addr >= BASE_ADDR) && (slot < WIDTH'(SLAVES));

    // One select line per slave; at most one can match the slot number.
    generate
        for (genvar gi = 0; gi < SLAVES; gi++) begin : g_sel
            assign sel[gi] = hit && (slot == WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/modport_bridge.sv
// AHB-Lite slave to APB master bridge. Each accepted AHB beat becomes one APB
// setup+enable transfer; the AHB data phase is stretched with Hreadyout.
// All bus outputs are registered from the FSM next state.
// Optional macro BRIDGE_ERR_EN: out-of-window active beats receive a
// two-cycle AHB ERROR response instead of being silently ignored.
module modport_bridge
    import bridge_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               SLAVES    = DEFAULT_SLAVES,
    parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(32'h8000_0000),
    parameter int               SLOT_BITS = 26
) (
    input  logic              clock,
    input  logic              Hresetn,
    input  logic [1:0]        Htrans,
    input  logic [2:0]        Hsize,
    input  logic [2:0]        Hburst,
    input  logic              Hreadyin,
    input  logic              Hwrite,
    input  logic [WIDTH-1:0]  Haddr,
    input  logic [WIDTH-1:0]  Hwdata,
    output logic [WIDTH-1:0]  Hrdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    input  logic [WIDTH-1:0]  Prdata,
    output logic [SLAVES-1:0] Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [WIDTH-1:0]  Paddr,
    output logic [WIDTH-1:0]  Pwdata
);

    state_t state_reg, state_next;

    logic [WIDTH-1:0]  addr_reg;
    logic [SLAVES-1:0] sel_reg;

    logic [SLAVES-1:0] pselx_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [WIDTH-1:0]  paddr_reg;
    logic [WIDTH-1:0]  pwdata_reg;
    logic              hreadyout_reg;
    logic [1:0]        hresp_reg;

    logic              dec_hit;
    logic [SLAVES-1:0] dec_sel;
    logic              active;
    logic              accept_window;
    logic              take;
    logic              err_beat;

    // Size and burst do not affect a full-word APB access; the low Htrans
    // bit only separates IDLE from BUSY, both of which are ignored.
    logic              unused_inputs;
    assign unused_inputs = ^{Hsize, Hburst};

    bridge_addr_decode #(
        .WIDTH     (WIDTH),
        .SLAVES    (SLAVES),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS)
    ) u_decode (
        .addr (Haddr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // A new address phase is only sampled in states that drive Hreadyout=1
    // and can chain straight into another transfer.
    assign active        = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);
    assign accept_window = (state_reg == IDLE) || (state_reg == RENABLE) ||
                           (state_reg == WENABLE);
    assign take          = accept_window && Hreadyin && active && dec_hit;
`ifdef BRIDGE_ERR_EN
    assign err_beat      = accept_window && Hreadyin && active && !dec_hit;
`else
    assign err_beat      = 1'b0;
`endif

    assign Hrdata    = Prdata;
    assign Hreadyout = hreadyout_reg;
    assign Hresp     = hresp_reg;
    assign Pselx     = pselx_reg;
    assign Penable   = penable_reg;
    assign Pwrite    = pwrite_reg;
    assign Paddr     = paddr_reg;
    assign Pwdata    = pwdata_reg;

    // Next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RENABLE, WENABLE: begin
                if (take)
                    state_next = Hwrite ? WWAIT : READ;
                else if (err_beat)
                    state_next = ERR1;
                else
                    state_next = IDLE;
            end
            READ:    state_next = RENABLE;
            WWAIT:   state_next = WRITE;
            WRITE:   state_next = WENABLE;
            ERR1:    state_next = ERR2;
            ERR2:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and the accepted beat's address/select.
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (take) begin
                addr_reg <= Haddr;
                sel_reg  <= dec_sel;
            end
        end
    end

    // Bus outputs decoded from the state being entered. Reads enter setup
    // directly from the address phase, so they use the live decode; writes
    // wait one cycle for Hwdata and use the latched address and select.
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            pselx_reg     <= '0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= HRESP_OKAY;
        end else begin
            penable_reg <= 1'b0;
            hresp_reg   <= HRESP_OKAY;
            case (state_next)
                READ: begin
                    pselx_reg     <= dec_sel;
                    paddr_reg     <= Haddr;
                    pwrite_reg    <= 1'b0;
                    hreadyout_reg <= 1'b0;
                end
                RENABLE, WENABLE: begin
                    penable_reg   <= 1'b1;
                    hreadyout_reg <= 1'b1;
                end
                WWAIT: begin
                    pselx_reg     <= '0;
                    hreadyout_reg <= 1'b0;
                end
                WRITE: begin
                    pselx_reg     <= sel_reg;
                    paddr_reg     <= addr_reg;
                    pwrite_reg    <= 1'b1;
                    pwdata_reg    <= Hwdata;
                    hreadyout_reg <= 1'b0;
                end
                ERR1: begin
                    pselx_reg     <= '0;
                    hreadyout_reg <= 1'b0;
                    hresp_reg     <= HRESP_ERROR;
                end
                ERR2: begin
                    pselx_reg     <= '0;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= HRESP_ERROR;
                end
                default: begin
                    pselx_reg     <= '0;
                    hreadyout_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modport_bridge.sv
// Directed bench for modport_bridge: reset, read, write, back-to-back,
// out-of-window, window boundary, idle/busy beats and reset abort.
module tb_modport_bridge;

    logic        clock;
    logic        hresetn;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hreadyin;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] prdata;
    logic [3:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int n_cmp;
    int n_bad;

    // {pselx, penable, pwrite, hreadyout, hresp}
    logic [8:0] bus;
    assign bus = {pselx, penable, pwrite, hreadyout, hresp};

    modport_bridge dut (
        .clock     (clock),
        .Hresetn   (hresetn),
        .Htrans    (htrans),
        .Hsize     (hsize),
        .Hburst    (hburst),
        .Hreadyin  (hreadyin),
        .Hwrite    (hwrite),
        .Haddr     (haddr),
        .Hwdata    (hwdata),
        .Hrdata    (hrdata),
        .Hreadyout (hreadyout),
        .Hresp     (hresp),
        .Prdata    (prdata),
        .Pselx     (pselx),
        .Penable   (penable),
        .Pwrite    (pwrite),
        .Paddr     (paddr),
        .Pwdata    (pwdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [1:0] t, input logic w, input logic [31:0] a);
        htrans = t;
        hwrite = w;
        haddr  = a;
    endtask

    task automatic test_reset;
        hresetn = 1'b0; htrans = 2'b00; hsize = 3'b010; hburst = 3'b000;
        hreadyin = 1'b1; hwrite = 1'b0; haddr = '0; hwdata = '0; prdata = '0;
        step(); step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
        n_cmp++;
        if ({paddr, pwdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {paddr, pwdata});
        end
        hresetn = 1'b1;
        step();
        $display("txn reset: bus=%b", bus);
    endtask

    task automatic test_read;
        beat(2'b10, 1'b0, 32'h8000_0010);
        step();
        beat(2'b00, 1'b0, 32'h0);
        n_cmp++;
        if (bus !== 9'b0001_0_0_0_00) begin
            n_bad++; $display("FAIL read_setup: got %b want %b", bus, 9'b0001_0_0_0_00);
        end
        n_cmp++;
        if (paddr !== 32'h8000_0010) begin
            n_bad++; $display("FAIL read_paddr: got %h want 80000010", paddr);
        end
        step();
        prdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (bus !== 9'b0001_1_0_1_00) begin
            n_bad++; $display("FAIL read_enable: got %b want %b", bus, 9'b0001_1_0_1_00);
        end
        n_cmp++;
        if (hrdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL read_hrdata: got %h want deadbeef", hrdata);
        end
        step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL read_idle: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
        $display("txn read 80000010: hrdata=%h", hrdata);
    endtask

    task automatic test_write;
        beat(2'b10, 1'b1, 32'h8C00_0004);
        step();
        beat(2'b00, 1'b0, 32'h0);
        hwdata = 32'h1234_5678;
        n_cmp++;
        if (bus !== 9'b0000_0_0_0_00) begin
            n_bad++; $display("FAIL write_wait: got %b want %b", bus, 9'b0000_0_0_0_00);
        end
        step();
        hwdata = 32'hFFFF_FFFF;
        n_cmp++;
        if (bus !== 9'b1000_0_1_0_00) begin
            n_bad++; $display("FAIL write_setup: got %b want %b", bus, 9'b1000_0_1_0_00);
        end
        n_cmp++;
        if ({paddr, pwdata} !== {32'h8C00_0004, 32'h1234_5678}) begin
            n_bad++; $display("FAIL write_data: got %h want 8c00000412345678", {paddr, pwdata});
        end
        step();
        n_cmp++;
        if (bus !== 9'b1000_1_1_1_00) begin
            n_bad++; $display("FAIL write_enable: got %b want %b", bus, 9'b1000_1_1_1_00);
        end
        step();
        n_cmp++;
        if ({bus, paddr, pwdata} !== {9'b0000_0_1_1_00, 32'h8C00_0004, 32'h1234_5678}) begin
            n_bad++; $display("FAIL write_hold: got %b %h %h", bus, paddr, pwdata);
        end
        $display("txn write 8c000004: pwdata=%h", pwdata);
    endtask

    task automatic test_back_to_back;
        beat(2'b10, 1'b1, 32'h8400_0000);
        step();
        beat(2'b00, 1'b0, 32'h0);
        hwdata = 32'hA5A5_0001;
        step();
        n_cmp++;
        if (bus !== 9'b0010_0_1_0_00) begin
            n_bad++; $display("FAIL b2b_wsetup: got %b want %b", bus, 9'b0010_0_1_0_00);
        end
        step();
        beat(2'b10, 1'b0, 32'h8800_0000);
        n_cmp++;
        if (bus !== 9'b0010_1_1_1_00) begin
            n_bad++; $display("FAIL b2b_wenable: got %b want %b", bus, 9'b0010_1_1_1_00);
        end
        step();
        beat(2'b00, 1'b0, 32'h0);
        n_cmp++;
        if ({bus, paddr} !== {9'b0100_0_0_0_00, 32'h8800_0000}) begin
            n_bad++; $display("FAIL b2b_rsetup: got %b %h want 0100000_00 88000000", bus, paddr);
        end
        step();
        n_cmp++;
        if (bus !== 9'b0100_1_0_1_00) begin
            n_bad++; $display("FAIL b2b_renable: got %b want %b", bus, 9'b0100_1_0_1_00);
        end
        step();
        $display("txn b2b write 84000000 then read 88000000");
    endtask

    task automatic test_miss;
        beat(2'b10, 1'b0, 32'h7000_0000);
        step();
        beat(2'b00, 1'b0, 32'h0);
`ifdef BRIDGE_ERR_EN
        n_cmp++;
        if (bus !== 9'b0000_0_0_0_01) begin
            n_bad++; $display("FAIL miss_err1: got %b want %b", bus, 9'b0000_0_0_0_01);
        end
        step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_01) begin
            n_bad++; $display("FAIL miss_err2: got %b want %b", bus, 9'b0000_0_0_1_01);
        end
`else
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL miss_okay: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
`endif
        step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL miss_after: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
        $display("txn miss 70000000: hresp=%b", hresp);
    endtask

    task automatic test_boundary;
        beat(2'b11, 1'b0, 32'h8FFF_FFFC);
        step();
        beat(2'b00, 1'b0, 32'h0);
        n_cmp++;
        if ({bus, paddr} !== {9'b1000_0_0_0_00, 32'h8FFF_FFFC}) begin
            n_bad++; $display("FAIL top_slot: got %b %h want 100000000 8ffffffc", bus, paddr);
        end
        step(); step();
        beat(2'b10, 1'b0, 32'h9000_0000);
        step();
        beat(2'b00, 1'b0, 32'h0);
`ifdef BRIDGE_ERR_EN
        n_cmp++;
        if (bus !== 9'b0000_0_0_0_01) begin
            n_bad++; $display("FAIL above_window: got %b want %b", bus, 9'b0000_0_0_0_01);
        end
        step();
`else
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL above_window: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
`endif
        step();
        $display("txn boundary 8ffffffc hit, 90000000 miss");
    endtask

    task automatic test_busy_notready;
        beat(2'b01, 1'b0, 32'h8000_0000);
        step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL busy: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
        beat(2'b10, 1'b1, 32'h8000_0000);
        hreadyin = 1'b0;
        step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL notready_1: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
        step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL notready_2: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
        hreadyin = 1'b1;
        beat(2'b00, 1'b0, 32'h0);
        $display("txn busy/notready: no apb transfer");
    endtask

    task automatic test_reset_abort;
        beat(2'b10, 1'b1, 32'h8000_0008);
        step();
        beat(2'b00, 1'b0, 32'h0);
        hwdata = 32'hCAFE_0008;
        step();
        n_cmp++;
        if (bus !== 9'b0001_0_1_0_00) begin
            n_bad++; $display("FAIL abort_setup: got %b want %b", bus, 9'b0001_0_1_0_00);
        end
        hresetn = 1'b0;
        step();
        n_cmp++;
        if ({bus, paddr, pwdata} !== {9'b0000_0_0_1_00, 64'h0}) begin
            n_bad++; $display("FAIL abort_reset: got %b %h %h", bus, paddr, pwdata);
        end
        hresetn = 1'b1;
        step();
        n_cmp++;
        if (bus !== 9'b0000_0_0_1_00) begin
            n_bad++; $display("FAIL abort_after: got %b want %b", bus, 9'b0000_0_0_1_00);
        end
        $display("txn reset abort during write");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_miss();
        test_boundary();
        test_busy_notready();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
